// File: rtl/acia_rx_fifo.sv
// ACIA receive front end: rx synchroniser, 8N1 deserialiser FSM and a small byte FIFO
// with sticky overrun / framing-error flags.
module acia_rx_fifo #(
  parameter int unsigned CLOCK      = 2000000,
  parameter int unsigned BAUD       = 19200,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  input  logic                  rd,
  input  logic                  clr_err,
  output logic [7:0]            data_out,
  output logic                  rx_valid,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overrun,
  output logic                  framing_err
);

  localparam int unsigned DIV   = CLOCK / BAUD;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned TW    = (DIV > 2) ? $clog2(DIV) : 2;

  localparam logic [TW-1:0]         TMR_FULL = TW'(DIV - 1);
  localparam logic [TW-1:0]         TMR_HALF = TW'(DIV / 2 - 1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic                  r_rx_meta;
  logic                  r_rxs;
  state_t                r_state;
  state_t                w_state_nxt;
  logic [TW-1:0]         r_tmr;
  logic [TW-1:0]         w_tmr_nxt;
  logic [2:0]            r_idx;
  logic [2:0]            w_idx_nxt;
  logic [7:0]            r_shift;
  logic [7:0]            w_shift_nxt;
  logic                  w_push;
  logic                  w_frame_err;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2-1:0] w_rptr_nxt;
  logic [DEPTH_LOG2:0]   r_count;
  logic [DEPTH_LOG2:0]   w_count_nxt;
  logic [7:0]            r_data_out;
  logic [7:0]            w_head_nxt;
  logic                  r_overrun;
  logic                  r_framing;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_wr;
  logic                  w_ovr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rxs     <= r_rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rxs) begin
          w_state_nxt = S_START;
          w_tmr_nxt   = TMR_HALF;
        end
      end
      S_START: begin
        if (r_tmr != '0) begin
          w_tmr_nxt = r_tmr - 1'b1;
        end else if (!r_rxs) begin
          w_state_nxt = S_DATA;
          w_tmr_nxt   = TMR_FULL;
          w_idx_nxt   = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        if (r_tmr != '0) begin
          w_tmr_nxt = r_tmr - 1'b1;
        end else begin
          w_shift_nxt[r_idx] = r_rxs;
          w_tmr_nxt          = TMR_FULL;
          w_idx_nxt          = r_idx + 1'b1;
          if (r_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (r_tmr != '0) begin
          w_tmr_nxt = r_tmr - 1'b1;
        end else begin
          w_push      = r_rxs;
          w_frame_err = !r_rxs;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_full = (r_count == CNT_FULL);
  assign w_pop  = rd && (r_count != '0);
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_ovr  = w_push && w_full && !w_pop;

  always_comb begin
    w_rptr_nxt  = w_pop ? r_rptr + 1'b1 : r_rptr;
    w_count_nxt = r_count;
    if (w_wr && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_wr && w_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
    // Head is precomputed so data_out is valid in the same cycle rx_valid rises;
    // a byte written into the slot that becomes head bypasses the memory.
    if (w_wr && (r_wptr == w_rptr_nxt)) begin
      w_head_nxt = r_shift;
    end else begin
      w_head_nxt = r_mem[w_rptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && !reset) begin
      r_mem[r_wptr] <= r_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_data_out <= '0;
      r_overrun  <= 1'b0;
      r_framing  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
      if (w_count_nxt != '0) begin
        r_data_out <= w_head_nxt;
      end
      r_overrun <= (r_overrun && !clr_err) || w_ovr;
      r_framing <= (r_framing && !clr_err) || w_frame_err;
    end
  end

  assign data_out    = r_data_out;
  assign rx_valid    = (r_count != '0);
  assign count       = r_count;
  assign overrun     = r_overrun;
  assign framing_err = r_framing;

endmodule

// File: tb/tb_acia_rx_fifo.sv
// Directed bench for acia_rx_fifo: 8N1 frames driven bit-by-bit, expected bytes kept
// in a queue and compared as they are popped.
module tb_acia_rx_fifo;

  localparam int BIT   = 104;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rd;
  logic       clr_err;
  logic [7:0] data_out;
  logic       rx_valid;
  logic [4:0] count;
  logic       overrun;
  logic       framing_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] q[$];
  logic       exp_ovr;
  logic       exp_fe;

  always #5 clk = ~clk;

  acia_rx_fifo #(
    .CLOCK      (2000000),
    .BAUD       (19200),
    .DEPTH_LOG2 (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .rd          (rd),
    .clr_err     (clr_err),
    .data_out    (data_out),
    .rx_valid    (rx_valid),
    .count       (count),
    .overrun     (overrun),
    .framing_err (framing_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame starting just after a rising edge. rd_at: cycle index at which rd is
  // asserted for one clock (-1 none). rst_at: cycle index of a one-clock reset that aborts the frame.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int rd_at, input int rst_at);
    logic [9:0] bits;
    logic       popped;
    bits   = {stop, d, 1'b0};
    popped = 1'b0;
    for (int c = 0; c < 10 * BIT; c++) begin
      rx    = bits[c / BIT];
      rd    = 1'b0;
      reset = 1'b0;
      if (c == rd_at) begin
        if (q.size() > 0) begin
          chk("pop_head_at_stop", data_out, q[0]);
          void'(q.pop_front());
          popped = 1'b1;
        end
        rd = 1'b1;
      end
      if (c == rst_at) reset = 1'b1;
      if (rst_at >= 0 && c == rst_at + 2) break;
      @(posedge clk);
      #1;
    end
    rx    = 1'b1;
    rd    = 1'b0;
    reset = 1'b0;
    if (rst_at >= 0) begin
      q.delete();
      exp_ovr = 1'b0;
      exp_fe  = 1'b0;
    end else if (!stop) begin
      exp_fe = 1'b1;
    end else if (q.size() < DEPTH) begin
      q.push_back(d);
    end else begin
      exp_ovr = 1'b1;
    end
  endtask

  task automatic read_one(input string tag);
    logic [7:0] e;
    chk({tag, "_valid"}, rx_valid, 1'b1);
    e = (q.size() > 0) ? q.pop_front() : 8'hxx;
    chk({tag, "_data"}, data_out, e);
    rd = 1'b1;
    @(posedge clk);
    #1;
    rd = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    rx      = 1'b1;
    rd      = 1'b0;
    clr_err = 1'b0;
    exp_ovr = 1'b0;
    exp_fe  = 1'b0;
    step(3);
    chk("rst_count", count, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_ovr", overrun, 0);
    chk("rst_fe", framing_err, 0);
    reset = 1'b0;
    step(20);

    // 1) single byte, then pop
    send_frame(8'h55, 1'b1, -1, -1);
    step(10);
    chk("t1_valid", rx_valid, 1);
    chk("t1_count", count, q.size());
    chk("t1_count1", count, 1);
    read_one("t1_rd");
    chk("t1_count_after", count, 0);
    chk("t1_valid_after", rx_valid, 0);

    // 2) short low glitch rejected
    rx = 1'b0;
    step(40);
    rx = 1'b1;
    step(200);
    chk("t2_count", count, 0);
    chk("t2_fe", framing_err, 0);
    chk("t2_valid", rx_valid, 0);

    // 3) framing error and clear
    send_frame(8'hA3, 1'b0, -1, -1);
    step(150);
    chk("t3_fe", framing_err, exp_fe);
    chk("t3_count", count, 0);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    exp_fe  = 1'b0;
    chk("t3_fe_clr", framing_err, 0);

    // 4) overfill by one, then drain in order
    for (int i = 0; i <= 16; i++) begin
      send_frame(8'(i), 1'b1, -1, -1);
      step(5);
    end
    chk("t4_count", count, DEPTH);
    chk("t4_ovr", overrun, exp_ovr);
    chk("t4_ovr1", overrun, 1);
    for (int i = 0; i < DEPTH; i++) read_one("t4_drain");
    chk("t4_empty", count, 0);
    rd = 1'b1;
    step(3);
    rd = 1'b0;
    chk("t4_no_underflow", count, 0);
    chk("t4_valid_empty", rx_valid, 0);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    exp_ovr = 1'b0;
    chk("t4_ovr_clr", overrun, 0);

    // 5) full FIFO with a pop coinciding with the push of the 17th byte
    for (int i = 0; i < DEPTH; i++) begin
      send_frame(8'h20 + 8'(i), 1'b1, -1, -1);
      step(5);
    end
    chk("t5_full", count, DEPTH);
    send_frame(8'h10, 1'b1, 990, -1);
    step(5);
    chk("t5_ovr", overrun, 0);
    chk("t5_count", count, DEPTH);
    chk("t5_model_size", count, q.size());
    for (int i = 0; i < DEPTH; i++) read_one("t5_drain");
    chk("t5_empty", count, 0);

    // 6) reset in the middle of a frame
    send_frame(8'h77, 1'b1, -1, -1);
    step(5);
    send_frame(8'h99, 1'b0, -1, -1);
    step(150);
    chk("t6_pre_fe", framing_err, 1);
    chk("t6_pre_count", count, 1);
    send_frame(8'h3C, 1'b1, -1, 400);
    step(200);
    chk("t6_count", count, 0);
    chk("t6_valid", rx_valid, 0);
    chk("t6_fe", framing_err, 0);
    chk("t6_ovr", overrun, 0);
    chk("t6_data", data_out, 8'h00);
    send_frame(8'h41, 1'b1, -1, -1);
    step(5);
    chk("t6_count1", count, 1);
    read_one("t6_rd");
    chk("t6_count_end", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
